// File: rtl/config.sv
// ============================================================================
// Module   : pipe_hazard_cfg_pkg
// Brief    : Core-wide configuration constants shared by the pipeline blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_cfg_pkg;
    localparam int REG_ADDRW = 5;
endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Hazard-controller state type, timeout default and load-use helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;
    import pipe_hazard_cfg_pkg::*;

    localparam int HZD_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2
    } hazard_state_e;

    // A load in EX whose destination is read by the instruction in ID; x0 never hazards.
    function automatic logic hzd_load_use(
        input logic                 exu_lden,
        input logic                 exu_rdwen,
        input logic [REG_ADDRW-1:0] exu_rdid,
        input logic                 idu_rs1en,
        input logic [REG_ADDRW-1:0] idu_rs1id,
        input logic                 idu_rs2en,
        input logic [REG_ADDRW-1:0] idu_rs2id
    );
        return exu_lden && exu_rdwen && (exu_rdid != '0) &&
               ((idu_rs1en && (idu_rs1id == exu_rdid)) ||
                (idu_rs2en && (idu_rs2id == exu_rdid)));
    endfunction
endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Pipeline <-> hazard controller signal bundle (master = pipeline).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
    import pipe_hazard_cfg_pkg::*;

    logic [REG_ADDRW-1:0] i_idu_rs1id;
    logic [REG_ADDRW-1:0] i_idu_rs2id;
    logic                 i_idu_rs1en;
    logic                 i_idu_rs2en;
    logic [REG_ADDRW-1:0] i_exu_rdid;
    logic                 i_exu_rdwen;
    logic                 i_exu_lden;
    logic                 i_exu_redirect;
    logic                 i_lsu_req;
    logic                 i_lsu_ack;

    logic                 o_pc_stall;
    logic                 o_ifid_stall;
    logic                 o_ifid_flush;
    logic                 o_idex_bubble;
    logic                 o_exmem_stall;
    logic                 o_memwb_bubble;
    logic                 o_mem_timeout;

    modport master (
        output i_idu_rs1id, i_idu_rs2id, i_idu_rs1en, i_idu_rs2en,
        output i_exu_rdid, i_exu_rdwen, i_exu_lden, i_exu_redirect,
        output i_lsu_req, i_lsu_ack,
        input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble,
        input  o_exmem_stall, o_memwb_bubble, o_mem_timeout
    );

    modport slave (
        input  i_idu_rs1id, i_idu_rs2id, i_idu_rs1en, i_idu_rs2en,
        input  i_exu_rdid, i_exu_rdwen, i_exu_lden, i_exu_redirect,
        input  i_lsu_req, i_lsu_ack,
        output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble,
        output o_exmem_stall, o_memwb_bubble, o_mem_timeout
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// ============================================================================
// Module   : hazard_perf_cnt
// Brief    : Free-running 64-bit event counter with enable, wraps at 2^64.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_perf_cnt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [63:0] o_count
);
    logic [63:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;
endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Load-use / redirect / memory-wait stall and flush controller.
//            Define HAZARD_PERF_EN to add 64-bit perf counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = HZD_TIMEOUT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    pipe_hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [63:0]        o_perf_ldstall,
    output logic [63:0]        o_perf_memstall,
    output logic [63:0]        o_perf_flush
`endif
);
    localparam logic [1:0] C_ST_IDLE    = IDLE;
    localparam logic [1:0] C_ST_LDUSE   = LDUSE;
    localparam logic [1:0] C_ST_MEMWAIT = MEMWAIT;

    // The cycle that enters MEMWAIT is wait cycle 1, so a counter value of
    // 2^W-2 in MEMWAIT marks the (2^W-1)th wait cycle.
    localparam logic [TIMEOUT_W-1:0] C_CNT_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [TIMEOUT_W-1:0] r_cnt;

    logic w_hazard_lu;
    logic w_mem_busy;
    logic w_timeout;
    logic w_stall_mem;
    logic w_redirect;
    logic w_lu_stall;
    logic w_run;

    assign w_hazard_lu = hzd_load_use(bus.i_exu_lden, bus.i_exu_rdwen, bus.i_exu_rdid,
                                      bus.i_idu_rs1en, bus.i_idu_rs1id,
                                      bus.i_idu_rs2en, bus.i_idu_rs2id);

    assign w_mem_busy  = bus.i_lsu_req & ~bus.i_lsu_ack;
    assign w_timeout   = (r_state == C_ST_MEMWAIT) & w_mem_busy & (r_cnt == C_CNT_LAST);
    assign w_stall_mem = w_mem_busy & ~w_timeout;

    // Any cycle that is not a memory stall lets EX advance, so a pending redirect is taken.
    assign w_redirect  = bus.i_exu_redirect & ~w_stall_mem;
    assign w_lu_stall  = (r_state == C_ST_IDLE) & w_hazard_lu & ~w_mem_busy
                         & ~bus.i_exu_redirect;

    assign w_run = ~i_rst;

    assign bus.o_pc_stall     = w_run & (w_stall_mem | w_lu_stall);
    assign bus.o_ifid_stall   = w_run & (w_stall_mem | w_lu_stall);
    assign bus.o_ifid_flush   = w_run & w_redirect;
    assign bus.o_idex_bubble  = w_run & (w_redirect | w_lu_stall);
    assign bus.o_exmem_stall  = w_run & w_stall_mem;
    assign bus.o_memwb_bubble = w_run & w_stall_mem;
    assign bus.o_mem_timeout  = w_run & w_timeout;

    always_comb begin
        w_next_state = C_ST_IDLE;
        if (w_stall_mem) begin
            w_next_state = C_ST_MEMWAIT;
        end else if (w_lu_stall) begin
            w_next_state = C_ST_LDUSE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= (w_next_state == C_ST_MEMWAIT) ? r_cnt + TIMEOUT_W'(1) : '0;
        end
    end

    a_flush_vs_stall : assert property (@(posedge i_clk) disable iff (i_rst)
        !(bus.o_ifid_flush && bus.o_ifid_stall));
    a_bubble_vs_stall : assert property (@(posedge i_clk) disable iff (i_rst)
        !(bus.o_idex_bubble && bus.o_exmem_stall));

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf_ldstall (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_run & w_lu_stall),
        .o_count (o_perf_ldstall)
    );

    hazard_perf_cnt u_perf_memstall (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (bus.o_exmem_stall),
        .o_count (o_perf_memstall)
    );

    hazard_perf_cnt u_perf_flush (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (bus.o_ifid_flush),
        .o_count (o_perf_flush)
    );
`endif
endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench for pipe_hazard_ctrl (TIMEOUT_W=3), directed + random.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;
    import pipe_hazard_cfg_pkg::*;

    localparam int TW         = 3;
    localparam int WAIT_LIMIT = (1 << TW) - 1;

    // Expected vector order: pc_stall, ifid_stall, ifid_flush, idex_bubble,
    // exmem_stall, memwb_bubble, mem_timeout
    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_MEM   = 7'b1100110;
    localparam logic [6:0] E_FLUSH = 7'b0011000;
    localparam logic [6:0] E_LU    = 7'b1101000;

    logic clk = 1'b0;
    logic rst;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.TIMEOUT_W(TW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] exp_q[$];
    string      tag_q[$];
    int         checks   = 0;
    int         failures = 0;

    // Reference model: whether a memory wait is in progress, how many wait
    // cycles it has used, and whether the previous cycle was a load-use stall.
    bit m_waiting   = 1'b0;
    int m_wait_cyc  = 0;
    bit m_lu_prev   = 1'b0;

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.i_idu_rs1id    = '0;
        bus.i_idu_rs2id    = '0;
        bus.i_idu_rs1en    = 1'b0;
        bus.i_idu_rs2en    = 1'b0;
        bus.i_exu_rdid     = '0;
        bus.i_exu_rdwen    = 1'b0;
        bus.i_exu_lden     = 1'b0;
        bus.i_exu_redirect = 1'b0;
        bus.i_lsu_req      = 1'b0;
        bus.i_lsu_ack      = 1'b0;
    endtask

    task automatic set_ld(input logic [REG_ADDRW-1:0] rd, input logic en1,
                          input logic [REG_ADDRW-1:0] rs1, input logic en2,
                          input logic [REG_ADDRW-1:0] rs2);
        bus.i_exu_lden  = 1'b1;
        bus.i_exu_rdwen = 1'b1;
        bus.i_exu_rdid  = rd;
        bus.i_idu_rs1en = en1;
        bus.i_idu_rs1id = rs1;
        bus.i_idu_rs2en = en2;
        bus.i_idu_rs2id = rs2;
    endtask

    // Evaluate the model for the inputs now applied and queue the expectation.
    task automatic expect_cycle(input string tag);
        logic [6:0] e;
        bit busy, hz, lu;
        e    = E_NONE;
        lu   = 1'b0;
        busy = bus.i_lsu_req && !bus.i_lsu_ack;
        hz   = bus.i_exu_lden && bus.i_exu_rdwen && (bus.i_exu_rdid != '0) &&
               ((bus.i_idu_rs1en && bus.i_idu_rs1id == bus.i_exu_rdid) ||
                (bus.i_idu_rs2en && bus.i_idu_rs2id == bus.i_exu_rdid));
        if (rst) begin
            m_waiting  = 1'b0;
            m_wait_cyc = 0;
        end else if (m_waiting) begin
            if (busy && (m_wait_cyc + 1 < WAIT_LIMIT)) begin
                e = E_MEM;
                m_wait_cyc++;
            end else begin
                if (bus.i_exu_redirect) e = E_FLUSH;
                if (busy) e[0] = 1'b1;
                m_waiting  = 1'b0;
                m_wait_cyc = 0;
            end
        end else if (busy) begin
            e          = E_MEM;
            m_waiting  = 1'b1;
            m_wait_cyc = 1;
        end else if (bus.i_exu_redirect) begin
            e = E_FLUSH;
        end else if (hz && !m_lu_prev) begin
            e  = E_LU;
            lu = 1'b1;
        end
        m_lu_prev = lu;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step(input string tag);
        expect_cycle(tag);
        next_cyc();
    endtask

    // Monitor: outputs are combinational, so one response is due per cycle.
    always @(negedge clk) begin
        logic [6:0] act;
        logic [6:0] e;
        string      t;
        act = {bus.o_pc_stall, bus.o_ifid_stall, bus.o_ifid_flush, bus.o_idex_bubble,
               bus.o_exmem_stall, bus.o_memwb_bubble, bus.o_mem_timeout};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: outputs got %b expected %b (pc ifid flush idexb exmem memwbb tmo) t=%0t",
                         t, act, e, $time);
            end
            checks++;
            if ((act[5] && act[4]) || (act[3] && act[2])) begin
                failures++;
                $display("FAIL exclusive_%s: outputs got %b expected no flush+stall or bubble+stall",
                         t, act);
            end
        end
    end

    initial begin
        int req_left;
        bit ack_end;
        rst = 1'b1;
        clr();
        next_cyc();

        // Reset holds every output low even with all requests active
        bus.i_lsu_req = 1'b1; bus.i_exu_redirect = 1'b1;
        set_ld(5'd5, 1'b1, 5'd5, 1'b0, '0);
        step("reset_a");
        step("reset_b");
        rst = 1'b0; clr();
        step("idle");

        // Load-use on rs1: one stall cycle then released even with inputs held
        set_ld(5'd5, 1'b1, 5'd5, 1'b0, '0);
        step("lu_first");
        step("lu_second");
        clr();
        step("lu_after");
        set_ld(5'd7, 1'b0, 5'd7, 1'b1, 5'd7);
        step("lu_rs2");
        clr();
        step("lu_rs2_done");
        set_ld(5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        step("x0_load_a");
        step("x0_load_b");
        set_ld(5'd3, 1'b1, 5'd3, 1'b0, '0);
        bus.i_exu_rdwen = 1'b0;
        step("no_rdwen");
        clr();

        // Memory wait released on the ack cycle, then back in IDLE
        bus.i_lsu_req = 1'b1;
        for (int i = 0; i < 3; i++) step("memwait");
        bus.i_lsu_ack = 1'b1;
        step("mem_ack");
        clr();
        set_ld(5'd9, 1'b1, 5'd9, 1'b0, '0);
        step("lu_post_mem");
        clr();
        step("idle_post_mem");

        // Redirect held by a stalled EX is taken on the ack cycle
        bus.i_lsu_req = 1'b1; bus.i_exu_redirect = 1'b1;
        step("redir_wait_1");
        step("redir_wait_2");
        bus.i_lsu_ack = 1'b1;
        step("redir_on_ack");
        clr();
        bus.i_exu_redirect = 1'b1;
        set_ld(5'd4, 1'b1, 5'd4, 1'b0, '0);
        step("redir_over_lu");
        clr();

        // Request dropped mid-wait ends the wait
        bus.i_lsu_req = 1'b1;
        step("drop_wait_1");
        step("drop_wait_2");
        bus.i_lsu_req = 1'b0; bus.i_exu_redirect = 1'b1;
        step("drop_exit");
        clr();

        // Timeout: pulse on the 7th wait cycle, then the held request re-stalls
        bus.i_lsu_req = 1'b1;
        for (int i = 0; i < 10; i++) step("timeout_seq");
        clr();
        step("timeout_done");

        // Reset on wait cycle 2 aborts the wait; counter starts fresh afterwards
        bus.i_lsu_req = 1'b1;
        step("rst_wait_1");
        rst = 1'b1;
        #1;
        step("rst_wait_2");
        rst = 1'b0; clr();
        step("rst_released");
        bus.i_lsu_req = 1'b1;
        for (int i = 0; i < 8; i++) step("post_rst_wait");
        clr();
        step("post_rst_idle");

        // Randomised traffic with bursty memory requests
        req_left = 0;
        ack_end  = 1'b0;
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (req_left == 0 && $urandom_range(0, 4) == 0) begin
                req_left = $urandom_range(1, 10);
                ack_end  = $urandom_range(0, 1) == 1;
            end
            if (req_left > 0) begin
                bus.i_lsu_req = 1'b1;
                bus.i_lsu_ack = (req_left == 1) && ack_end;
                req_left--;
            end else begin
                bus.i_lsu_req = 1'b0;
                bus.i_lsu_ack = ($urandom_range(0, 7) == 0);
            end
            bus.i_exu_redirect = ($urandom_range(0, 4) == 0);
            bus.i_exu_lden     = $urandom_range(0, 1) == 1;
            bus.i_exu_rdwen    = $urandom_range(0, 3) != 0;
            bus.i_exu_rdid     = REG_ADDRW'($urandom_range(0, 3));
            bus.i_idu_rs1en    = $urandom_range(0, 1) == 1;
            bus.i_idu_rs1id    = REG_ADDRW'($urandom_range(0, 3));
            bus.i_idu_rs2en    = $urandom_range(0, 1) == 1;
            bus.i_idu_rs2id    = REG_ADDRW'($urandom_range(0, 3));
            step("random");
        end
        rst = 1'b0;
        clr();
        step("final_idle");

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending expectations got %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT_W, default 8, width of the memory-wait timeout counter.
REQ-002 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst  in  1  asynchronous, active-high reset.
REQ-004 i_idu_rs1id, i_idu_rs2id  in  REG_ADDRW  source register ids decoded in ID.
REQ-005 i_idu_rs1en, i_idu_rs2en  in  1  source operand actually used.
REQ-006 i_exu_rdid  in  REG_ADDRW; i_exu_rdwen, i_exu_lden  in  1  destination info of the instruction in the ID/EX register.
REQ-007 i_exu_redirect  in  1  taken branch or jump resolved in EX.
REQ-008 i_lsu_req, i_lsu_ack  in  1  data-memory request pending in MEM, and its completion.
REQ-009 o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble, o_exmem_stall, o_memwb_bubble  out  1  pipeline-register controls.
REQ-010 o_mem_timeout  out  1  single-cycle pulse on a memory-wait timeout.

Function
REQ-011 FSM states: IDLE, LDUSE, MEMWAIT.
REQ-012 hazard_lu = i_exu_lden & i_exu_rdwen & (i_exu_rdid != 0) & ((i_idu_rs1en & rs1id == rdid) | (i_idu_rs2en & rs2id == rdid)).
REQ-013 mem_busy = i_lsu_req & ~i_lsu_ack.
REQ-014 Priority in every state: mem_busy > i_exu_redirect > hazard_lu.
REQ-015 IDLE, mem_busy: o_pc_stall = o_ifid_stall = o_exmem_stall = 1, o_memwb_bubble = 1, o_idex_bubble = 0; next state is MEMWAIT.
REQ-016 IDLE, redirect (no mem_busy): o_ifid_flush = 1, o_idex_bubble = 1, no stalls; state stays IDLE.
REQ-017 IDLE, hazard_lu only: o_pc_stall = o_ifid_stall = 1, o_idex_bubble = 1; next state is LDUSE.
REQ-018 LDUSE lasts exactly one cycle: no load-use stall; mem_busy -> MEMWAIT, else -> IDLE; redirect is handled as in IDLE.
REQ-019 MEMWAIT: all stall outputs = 1 and o_memwb_bubble = 1; redirect and hazard_lu are ignored; the counter increments each cycle.
REQ-020 MEMWAIT exits to IDLE on i_lsu_ack, or if i_lsu_req drops; the counter clears on exit.
REQ-021 The i_lsu_ack cycle itself deasserts all stalls; a redirect still held by the stalled EX is honoured in that cycle.
REQ-022 If the counter reaches 2^TIMEOUT_W-1 with no ack: o_mem_timeout pulses, stalls release, state returns to IDLE, counter clears.
REQ-023 All outputs are combinational decode of state and inputs, with zero latency to the pipeline registers.
REQ-024 o_ifid_flush and o_ifid_stall are never both 1; o_idex_bubble and o_exmem_stall are never both 1.

Reset
REQ-025 While i_rst = 1: state is IDLE, the counter is 0, and every output is forced to 0 regardless of inputs.
REQ-026 Reset asserted mid-MEMWAIT aborts the wait immediately, with no timeout pulse.

Configuration
REQ-027 HAZARD_PERF_EN defined: adds outputs o_perf_ldstall, o_perf_memstall and o_perf_flush, each 64-bit, free-running and reset to 0.
REQ-028 Each counter increments once per cycle its event output is asserted; counters wrap at 2^64.
REQ-029 HAZARD_PERF_EN undefined: these ports and counters do not exist.

Structure
REQ-030 Shared package: hazard_state_e enum (IDLE, LDUSE, MEMWAIT) and the HZD_TIMEOUT_W default; REG_ADDRW comes from config.sv.
REQ-031 One sub-module, hazard_perf_cnt (one 64-bit counter with enable), instantiated three times under HAZARD_PERF_EN.

Verification
REQ-032 Load-use: exu lden=1, rdwen=1, rdid=5; idu rs1en=1, rs1id=5 -> one cycle of pc/ifid stall plus idex bubble, then no stall.
REQ-033 x0 load: same as REQ-032 with rdid=0 -> no stall, no bubble.
REQ-034 Memory wait: lsu_req=1, ack on the 4th cycle -> stalls for 3 cycles, released on the ack cycle, state returns to IDLE.
REQ-035 Redirect during MEMWAIT: redirect=1 and lsu_req=1 with ack on cycle 3 -> no flush on cycles 1-2, flush+bubble on cycle 3.
REQ-036 Timeout: TIMEOUT_W=3, lsu_req held with no ack -> o_mem_timeout pulses on the 7th wait cycle, then stalls drop.
REQ-037 Reset in MEMWAIT: i_rst pulsed on wait cycle 2 -> all outputs 0 at once; state is IDLE after release, no timeout pulse.
